player_input_conditioner: RTL and testbench

- Front-end for both tug-of-war players. Conditions two raw push-button keys into clean single-cycle move pulses L and R for the playfield light cells: center cell plus the normal cells on either side.
- Each channel does a two-flop synchronization, symmetric press/release debouncing, one pulse per press, and a lockout so that a key held through reset never produces a move.
- Sits between the board KEY pins and the light chain.

---
 rtl/player_input_conditioner.sv | 171 +++++++++++++++++
 tb/tb_player_input_conditioner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_conditioner.sv
// player_input_conditioner
//   Front-end for the two tug-of-war player keys. Each key runs through its
//   own channel: two-flop synchronizer, symmetric press/release debounce,
//   and a single registered move pulse per accepted press. Channels come out
//   of reset in HELD, so a key held through reset can never produce a move.
//
// Ports (top):
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   key_l_raw  in   left key, asynchronous, polarity set by ACTIVE_LOW
//   key_r_raw  in   right key, asynchronous, polarity set by ACTIVE_LOW
//   enable     in   1 = moves allowed, 0 = move pulses suppressed
//   L, R       out  one-cycle pulse per accepted left/right press
//   held_l/r   out  1 while that channel is in HELD or RELEASING
//
// Channel FSM:
//   state     | meaning
//   IDLE      | key debounced as released
//   ARMING    | press seen, counting stable pressed samples
//   HELD      | key debounced as pressed (also the reset state)
//   RELEASING | release seen, counting stable released samples

module player_input_conditioner_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_raw,
  input  logic i_enable,
  output logic o_pulse,
  output logic o_held
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMING,
    ST_HELD,
    ST_RELEASING
  } state_t;

  localparam logic             LP_INV  = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic             w_pressed;
  logic             r_s1;
  logic             r_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;

  assign w_pressed = i_key_raw ^ LP_INV;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1    <= 1'b0;
      r_s     <= 1'b0;
      r_state <= ST_HELD;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= w_pressed;
      r_s     <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s) begin
          w_state_nxt = ST_ARMING;
          w_cnt_nxt   = LP_ONE;
        end
      end
      ST_ARMING: begin
        if (!r_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          // enable is only looked at here: a press accepted while disabled
          // is consumed and never pulses later.
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_pulse_nxt = i_enable;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      ST_HELD: begin
        if (!r_s) begin
          w_state_nxt = ST_RELEASING;
          w_cnt_nxt   = LP_ONE;
        end
      end
      ST_RELEASING: begin
        if (r_s) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + LP_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_HELD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_pulse = r_pulse;
  assign o_held  = (r_state == ST_HELD) || (r_state == ST_RELEASING);

endmodule

module player_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_raw,
  input  logic key_r_raw,
  input  logic enable,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
);

  player_input_conditioner_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW),
    .CNT_W          (CNT_W)
  ) u_ch_l (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_key_raw(key_l_raw),
    .i_enable (enable),
    .o_pulse  (L),
    .o_held   (held_l)
  );

  player_input_conditioner_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW),
    .CNT_W          (CNT_W)
  ) u_ch_r (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_key_raw(key_r_raw),
    .i_enable (enable),
    .o_pulse  (R),
    .o_held   (held_r)
  );

endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Reference model: each channel keeps a debounced level; DEBOUNCE_CYCLES
// consecutive synchronized samples disagreeing with it flip it, and a 0->1
// flip taken while enable=1 is a move pulse. Expected pulses and held levels
// are queued by the model and consumed by an independent monitor.

module tb_player_input_conditioner;

  localparam int DC = 4;
  localparam int AL = 1;

  logic clk;
  logic reset;
  logic key_l_raw;
  logic key_r_raw;
  logic enable;
  logic L;
  logic R;
  logic held_l;
  logic held_r;

  player_input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (AL),
    .CNT_W          (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_l_raw(key_l_raw),
    .key_r_raw(key_r_raw),
    .enable   (enable),
    .L        (L),
    .R        (R),
    .held_l   (held_l),
    .held_r   (held_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int         q_l[$];
  int         q_r[$];
  logic [1:0] q_h[$];

  int n_l = 0;
  int n_r = 0;
  int last_l_cyc = -1;
  int last_r_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model, evaluated on every rising edge.
  int m_s1[2];
  int m_s[2];
  int m_deb[2];
  int m_run[2];

  initial begin : model
    int p[2];
    int pulse[2];
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s[c] = 0; m_deb[c] = 1; m_run[c] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      p[0] = (AL != 0) ? int'(!key_l_raw) : int'(key_l_raw);
      p[1] = (AL != 0) ? int'(!key_r_raw) : int'(key_r_raw);
      for (int c = 0; c < 2; c++) begin
        pulse[c] = 0;
        if (reset) begin
          m_s1[c] = 0; m_s[c] = 0; m_deb[c] = 1; m_run[c] = 0;
        end else begin
          if (m_s[c] != m_deb[c]) begin
            m_run[c]++;
            if (m_run[c] == DC) begin
              m_deb[c] = m_s[c];
              m_run[c] = 0;
              if (m_s[c] == 1 && enable) pulse[c] = 1;
            end
          end else begin
            m_run[c] = 0;
          end
          m_s[c]  = m_s1[c];
          m_s1[c] = p[c];
        end
      end
      if (pulse[0] != 0) q_l.push_back(cyc);
      if (pulse[1] != 0) q_r.push_back(cyc);
      q_h.push_back({1'(m_deb[0]), 1'(m_deb[1])});
    end
  end

  // Monitor: consumes model expectations as the DUT presents outputs.
  initial begin : monitor
    logic [1:0] h;
    forever begin
      @(negedge clk);
      if (q_h.size() > 0) begin
        h = q_h.pop_front();
        check("held_l", int'(held_l), int'(h[1]));
        check("held_r", int'(held_r), int'(h[0]));
      end
      if (L) begin
        n_l++;
        last_l_cyc = cyc;
        check("L_pulse_cycle", cyc, (q_l.size() > 0) ? q_l.pop_front() : -1);
      end else if (q_l.size() > 0 && q_l[0] <= cyc) begin
        void'(q_l.pop_front());
        check("L_pulse_missing", int'(L), 1);
      end
      if (R) begin
        n_r++;
        last_r_cyc = cyc;
        check("R_pulse_cycle", cyc, (q_r.size() > 0) ? q_r.pop_front() : -1);
      end else if (q_r.size() > 0 && q_r[0] <= cyc) begin
        void'(q_r.pop_front());
        check("R_pulse_missing", int'(R), 1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int bl, br, k, n, l_left, r_left;
    reset = 1'b1; key_l_raw = 1'b1; key_r_raw = 1'b1; enable = 1'b1;
    cycles(3);
    check("rst_L", int'(L), 0);
    check("rst_R", int'(R), 0);
    check("rst_held_l", int'(held_l), 1);
    check("rst_held_r", int'(held_r), 1);
    reset = 1'b0;
    cycles(10);

    // 1: clean press, first sampled at edge k, pulse visible after edge k+5
    bl = n_l; br = n_r;
    key_l_raw = 1'b0; k = cyc + 1;
    cycles(20);
    key_l_raw = 1'b1;
    cycles(20);
    check("t1_L_count", n_l - bl, 1);
    check("t1_R_count", n_r - br, 0);
    check("t1_latency", last_l_cyc, k + DC + 1);

    // 2: bounce reject, then one clean press
    br = n_r;
    key_r_raw = 1'b0; cycles(3);
    key_r_raw = 1'b1; cycles(1);
    key_r_raw = 1'b0; cycles(2);
    key_r_raw = 1'b1; cycles(10);
    check("t2_bounce_R", n_r - br, 0);
    key_r_raw = 1'b0; cycles(20);
    key_r_raw = 1'b1; cycles(20);
    check("t2_clean_R", n_r - br, 1);

    // 3: long hold with a short release glitch, then a second press
    bl = n_l;
    key_l_raw = 1'b0; cycles(20);
    key_l_raw = 1'b1; cycles(2);
    key_l_raw = 1'b0; cycles(28);
    key_l_raw = 1'b1; cycles(10);
    key_l_raw = 1'b0; cycles(10);
    key_l_raw = 1'b1; cycles(20);
    check("t3_L_count", n_l - bl, 2);

    // 4: simultaneous presses
    bl = n_l; br = n_r;
    key_l_raw = 1'b0; key_r_raw = 1'b0; cycles(15);
    key_l_raw = 1'b1; key_r_raw = 1'b1; cycles(20);
    check("t4_L_count", n_l - bl, 1);
    check("t4_R_count", n_r - br, 1);
    check("t4_same_cycle", last_l_cyc, last_r_cyc);

    // 5: press accepted while disabled is consumed
    bl = n_l;
    enable = 1'b0; key_l_raw = 1'b0; cycles(10);
    enable = 1'b1; cycles(10);
    key_l_raw = 1'b1; cycles(20);
    check("t5_disabled_L", n_l - bl, 0);
    key_l_raw = 1'b0; cycles(15);
    key_l_raw = 1'b1; cycles(20);
    check("t5_enabled_L", n_l - bl, 1);

    // 6a: key held across reset
    key_l_raw = 1'b0; cycles(10);
    bl = n_l;
    reset = 1'b1; cycles(3);
    reset = 1'b0; cycles(20);
    check("t6a_L_count", n_l - bl, 0);
    check("t6a_held_l", int'(held_l), 1);
    key_l_raw = 1'b1; cycles(20);

    // 6b: reset mid-ARMING, key then released
    bl = n_l;
    key_l_raw = 1'b0; cycles(4);
    reset = 1'b1; cycles(2);
    key_l_raw = 1'b1; cycles(1);
    reset = 1'b0; cycles(20);
    check("t6b_L_count", n_l - bl, 0);

    // 6c: idle key through reset; the synchronizer already reads released
    // on the first edge after reset, so RELEASING completes after DC edges.
    reset = 1'b1; cycles(3);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      n++;
      if (!held_l) break;
    end
    check("t6c_held_drop_edges", n, DC);
    cycles(5);

    // Randomized traffic against the model
    l_left = 0; r_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (l_left == 0) begin
        key_l_raw = 1'($urandom_range(0, 1));
        l_left = int'($urandom_range(1, 10));
      end
      if (r_left == 0) begin
        key_r_raw = 1'($urandom_range(0, 1));
        r_left = int'($urandom_range(1, 10));
      end
      l_left--; r_left--;
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    reset = 1'b0; enable = 1'b1; key_l_raw = 1'b1; key_r_raw = 1'b1;
    cycles(20);
    check("L_pending_at_end", q_l.size(), 0);
    check("R_pending_at_end", q_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
